// File: rtl/fm_radio_pkg.sv
// Shared constants and helpers for the FM receive chain.
// Used by the discriminator and the downstream audio stages.
package fm_radio_pkg;

    localparam int FM_DATA_WIDTH = 16;
    localparam int FM_OUT_WIDTH  = 16;
    localparam int FM_DECIM      = 40;

    // Working width of sat_signed; callers sign-extend into this width.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Resettable fixed-depth shift register that advances every clock.
// DEPTH=0 collapses to a plain wire.
module sample_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             i_sysclk_40,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_data = i_data;
        end else begin : g_sr
            logic [WIDTH-1:0] r_taps [DEPTH];

            always_ff @(posedge i_sysclk_40) begin
                if (i_rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_taps[k] <= '0;
                    end
                end else begin
                    r_taps[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_taps[k] <= r_taps[k-1];
                    end
                end
            end

            assign o_data = r_taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fm_discriminator.sv
// Cross-product FM discriminator (I*dQ - Q*dI) with integrate-and-dump.
// Define FM_DISC_SAT_EN to clamp o_data and report o_sat instead of wrapping.
module fm_discriminator
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH = FM_DATA_WIDTH,
    parameter int OUT_WIDTH  = FM_OUT_WIDTH,
    parameter int ALIGN_DLY  = 2,
    parameter int DECIM      = FM_DECIM,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                        i_sysclk_40,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_i_data,
    input  logic signed [DATA_WIDTH-1:0] i_q_data,
    input  logic signed [DATA_WIDTH-1:0] i_di_data,
    input  logic signed [DATA_WIDTH-1:0] i_dq_data,
    output logic signed [OUT_WIDTH-1:0]  o_data,
    output logic                        o_valid,
    output logic                        o_sat
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int DW    = PW + 1;
    localparam int ACC_W = DW + $clog2(DECIM);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DATA_WIDTH-1:0] w_i_al;
    logic [DATA_WIDTH-1:0] w_q_al;

    sample_delay_line #(.DEPTH(ALIGN_DLY), .WIDTH(DATA_WIDTH)) u_dly_i (
        .i_sysclk_40 (i_sysclk_40),
        .i_rst       (i_rst),
        .i_data      (i_i_data),
        .o_data      (w_i_al)
    );

    sample_delay_line #(.DEPTH(ALIGN_DLY), .WIDTH(DATA_WIDTH)) u_dly_q (
        .i_sysclk_40 (i_sysclk_40),
        .i_rst       (i_rst),
        .i_data      (i_q_data),
        .o_data      (w_q_al)
    );

    logic signed [DATA_WIDTH-1:0] r_i1, r_q1, r_di1, r_dq1;
    logic                         r_v1;
    logic signed [PW-1:0]         r_p1, r_p2;
    logic                         r_v2;
    logic signed [DW-1:0]         r_d;
    logic                         r_v3;
    logic signed [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]             r_cnt;
    logic signed [ACC_W-1:0]      r_dump;
    logic                         r_dump_v;
    logic signed [OUT_WIDTH-1:0]  r_data;
    logic                         r_valid;

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shifted;

    assign w_sum     = r_acc + ACC_W'(r_d);
    assign w_shifted = r_dump >>> OUT_SHIFT;

    always_ff @(posedge i_sysclk_40) begin
        if (i_rst) begin
            r_i1     <= '0;
            r_q1     <= '0;
            r_di1    <= '0;
            r_dq1    <= '0;
            r_v1     <= 1'b0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_v2     <= 1'b0;
            r_d      <= '0;
            r_v3     <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_dump   <= '0;
            r_dump_v <= 1'b0;
        end else begin
            r_i1     <= w_i_al;
            r_q1     <= w_q_al;
            r_di1    <= i_di_data;
            r_dq1    <= i_dq_data;
            r_v1     <= i_valid;
            r_p1     <= PW'(r_i1) * PW'(r_dq1);
            r_p2     <= PW'(r_q1) * PW'(r_di1);
            r_v2     <= r_v1;
            r_d      <= DW'(r_p1) - DW'(r_p2);
            r_v3     <= r_v2;
            r_dump_v <= 1'b0;
            if (r_v3) begin
                if (r_cnt == CNT_W'(DECIM - 1)) begin
                    r_dump   <= w_sum;
                    r_dump_v <= 1'b1;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef FM_DISC_SAT_EN
    logic signed [SAT_W-1:0] w_ext;
    logic signed [SAT_W-1:0] w_clip;
    logic                    r_sat;

    assign w_ext  = {{(SAT_W-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};
    assign w_clip = sat_signed(w_ext, OUT_WIDTH);

    // Shift/clip sits in its own register stage after the dump.
    always_ff @(posedge i_sysclk_40) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= r_dump_v;
            if (r_dump_v) begin
                r_data <= OUT_WIDTH'(w_clip);
                r_sat  <= (w_clip != w_ext);
            end
        end
    end

    assign o_sat = r_sat;
`else
    always_ff @(posedge i_sysclk_40) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_dump_v;
            if (r_dump_v) begin
                r_data <= OUT_WIDTH'(w_shifted);
            end
        end
    end

    assign o_sat = 1'b0;
`endif

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
